mem_stall_ctrl: RTL
===================

# mem_stall_ctrl

Sequencer that freezes the pipeline registers (IF/ID through MEM/WB) while the MEM stage waits on main memory. It detects load misses and write-through stores in MEM and runs the memory request/response handshake. It issues a one-cycle cache line fill, then releases the freeze for exactly one cycle so the stalled instruction advances. It also drives the shared `freeze` input of every pipeline register and keeps stall/miss performance counters.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum cycles in WAIT before abort.
- `CNT_W`, 32: width of `stall_cycles`.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_b`  in  1  asynchronous, active-high reset (asserted = 1), one clock domain.
- `mem_access`  in  1  MEM stage holds a load or store.
- `is_store`  in  1  MEM-stage access is a store; valid with `mem_access`.
- `cache_hit`  in  1  cache tag match for the MEM-stage address; combinational from cache.
- `mem_ready`  in  1  memory completion, one-cycle pulse.
- `freeze_ext`  in  1  external/debug freeze request.
- `freeze`  out  1  to all pipeline registers; 1 = hold.
- `mem_req`  out  1  memory request pulse.
- `mem_we`  out  1  write qualifier, valid with `mem_req`.
- `fill_en`  out  1  cache line write strobe.
- `timeout_err`  out  1  sticky abort flag.
- `stall_cycles`  out  CNT_W  cycles with `freeze`=1.
- `miss_count`  out  16  load misses plus stores, saturating.

## Operation
States: IDLE, REQ, WAIT, FILL, DONE (encoded in package).
- IDLE:
  - `mem_access & is_store` -> REQ (write-through).
  - `mem_access & ~is_store & ~cache_hit` -> REQ.
  - Otherwise stay in IDLE.
- REQ: `mem_req`=1, `mem_we`=latched `is_store`; always -> WAIT. The store/load type is latched on IDLE->REQ.
- WAIT: `wait_cnt` increments each cycle.
  - `mem_ready` & load -> FILL.
  - `mem_ready` & store -> DONE.
  - `wait_cnt`==TIMEOUT-1 without `mem_ready` -> set `timeout_err`, -> DONE.
  - `mem_ready` wins over timeout in the same cycle.
- FILL: `fill_en`=1 for one cycle; -> DONE.
- DONE: `freeze`=0, `mem_access` ignored; -> IDLE. This guarantees forward progress: the serviced instruction leaves MEM.
- `freeze` = `freeze_ext` | (IDLE & trigger) | REQ | WAIT | FILL. The IDLE term is combinational, so the freeze starts in the detecting cycle.
- `freeze_ext` does not alter FSM transitions. In DONE with `freeze_ext`=1 the pipeline stays held; the FSM still returns to IDLE and re-services a store. Software must not raise `freeze_ext` during stores.
- Counters:
  - `stall_cycles` increments every cycle `freeze`=1 and wraps modulo 2^CNT_W.
  - `miss_count` increments on each IDLE->REQ and saturates at 16'hFFFF.
  - `timeout_err` clears only on reset.
- `mem_ready` outside WAIT is ignored.

## Timing
- Reset (async, `rst_b`=1): state=IDLE, `wait_cnt`=0, `mem_req`=`mem_we`=`fill_en`=0, `timeout_err`=0, `stall_cycles`=0, `miss_count`=0.
- `freeze` during reset = `freeze_ext` only; the other trigger terms are gated off while `rst_b`=1.
- Reset mid-operation aborts any pending request; a late `mem_ready` is ignored.
- Load miss with `mem_ready` k cycles after `mem_req`: the freeze lasts k+3 cycles (IDLE, REQ, k-1 WAIT cycles, FILL, plus the mem_ready WAIT cycle). The release comes in DONE.
- `mem_req` is registered: high exactly one cycle, the cycle after detection.
- `fill_en` is high exactly one cycle, the cycle after `mem_ready`.

## Structure
- Package `mem_stall_pkg`: `stall_state_t` enum (IDLE, REQ, WAIT, FILL, DONE) and the default TIMEOUT constant.
- One sub-module, `sat_counter` (parameterised width, saturate/wrap select), instantiated twice for `miss_count` and `stall_cycles`.
- FSM and `wait_cnt` live in the top module.

## Test plan
- Load hit (`mem_access`=1, `is_store`=0, `cache_hit`=1) -> `freeze`=0 throughout, `miss_count` stays 0.
- Load miss, `mem_ready` 3 cycles after `mem_req` -> `freeze` high for 6 cycles, `fill_en` one pulse, DONE cycle `freeze`=0, `miss_count`=1, `stall_cycles`=6.
- Store hit -> `mem_req`=1 with `mem_we`=1, no `fill_en`, freeze released in DONE, no re-trigger while the same store is in DONE.
- No `mem_ready`, TIMEOUT=4 -> `timeout_err`=1 after 4 WAIT cycles, FSM passes DONE -> IDLE, flag stays set until reset.
- Async reset asserted mid-WAIT, then `mem_ready` pulse -> state IDLE, all counters 0, no `fill_en`.
- `freeze_ext`=1 during IDLE with no access -> `freeze`=1, `stall_cycles` increments, `miss_count` unchanged; `miss_count` preloaded to FFFF plus one miss -> stays FFFF.

Source files
------------

// File: rtl/mem_stall_ctrl_pkg.sv
// Shared types and constants for the MEM-stage stall controller.
// The FSM state encoding and the default memory timeout live here.
package mem_stall_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        FILL = 3'd3,
        DONE = 3'd4
    } stall_state_t;

    localparam int DEFAULT_TIMEOUT = 255;
    localparam int MISS_W          = 16;

    // Load misses and every store (write-through) need a trip to main memory.
    function automatic logic needs_service(input logic access,
                                           input logic store,
                                           input logic hit);
        return access & (store | ~hit);
    endfunction

endpackage

// File: rtl/mem_stall_ctrl_if.sv
// Bundle of the MEM-stage, memory-handshake and pipeline-freeze signals.
// The controller uses the slave modport; the pipeline/memory side uses master.
interface mem_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    import mem_stall_pkg::*;

    logic              mem_access;
    logic              is_store;
    logic              cache_hit;
    logic              mem_ready;
    logic              freeze_ext;
    logic              freeze;
    logic              mem_req;
    logic              mem_we;
    logic              fill_en;
    logic              timeout_err;
    logic [CNT_W-1:0]  stall_cycles;
    logic [MISS_W-1:0] miss_count;

    modport slave (
        input  mem_access,
        input  is_store,
        input  cache_hit,
        input  mem_ready,
        input  freeze_ext,
        output freeze,
        output mem_req,
        output mem_we,
        output fill_en,
        output timeout_err,
        output stall_cycles,
        output miss_count
    );

    modport master (
        output mem_access,
        output is_store,
        output cache_hit,
        output mem_ready,
        output freeze_ext,
        input  freeze,
        input  mem_req,
        input  mem_we,
        input  fill_en,
        input  timeout_err,
        input  stall_cycles,
        input  miss_count
    );

endinterface

// File: rtl/mem_stall_ctrl_sat_counter.sv
// Up-counter with a build-time choice between saturating at all-ones
// and wrapping modulo 2^WIDTH.
module sat_counter #(
    parameter int WIDTH    = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;
    logic             w_hold;

    assign w_hold  = SATURATE && (&r_count);
    assign o_count = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && !w_hold) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_stall_ctrl.sv
// Freezes the pipeline while the MEM stage waits on main memory, runs the
// request/response handshake, issues the line fill and keeps perf counters.
module mem_stall_ctrl
    import mem_stall_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 32
) (
    input logic             clk,
    input logic             rst_b,
    mem_stall_ctrl_if.slave bus
);

    localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    stall_state_t      r_state;
    stall_state_t      w_next;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_is_store;
    logic              r_timeout_err;

    logic w_trigger;
    logic w_start;
    logic w_expired;
    logic w_busy;
    logic w_mem_req;
    logic w_mem_we;
    logic w_fill_en;

    assign w_trigger = needs_service(bus.mem_access, bus.is_store, bus.cache_hit);
    assign w_start   = (r_state == IDLE) && w_trigger;
    assign w_expired = (r_state == WAIT) && !bus.mem_ready && (r_wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // DONE always returns to IDLE so the serviced instruction leaves MEM
    // before the trigger is looked at again.
    always_comb begin
        w_next    = r_state;
        w_busy    = 1'b0;
        w_mem_req = 1'b0;
        w_mem_we  = 1'b0;
        w_fill_en = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_trigger) begin
                    w_next = REQ;
                end
            end
            REQ: begin
                w_busy    = 1'b1;
                w_mem_req = 1'b1;
                w_mem_we  = r_is_store;
                w_next    = WAIT;
            end
            WAIT: begin
                w_busy = 1'b1;
                if (bus.mem_ready) begin
                    w_next = r_is_store ? DONE : FILL;
                end else if (w_expired) begin
                    w_next = DONE;
                end
            end
            FILL: begin
                w_busy    = 1'b1;
                w_fill_en = 1'b1;
                w_next    = DONE;
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            r_wait_cnt    <= '0;
            r_is_store    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == WAIT) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_start) begin
                r_is_store <= bus.is_store;
            end
            if (w_expired) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    // The IDLE term is combinational so the freeze covers the detecting cycle.
    assign bus.freeze      = bus.freeze_ext | (~rst_b & (w_start | w_busy));
    assign bus.mem_req     = w_mem_req;
    assign bus.mem_we      = w_mem_we;
    assign bus.fill_en     = w_fill_en;
    assign bus.timeout_err = r_timeout_err;

    sat_counter #(
        .WIDTH    (MISS_W),
        .SATURATE (1'b1)
    ) u_miss_cnt (
        .clk     (clk),
        .rst     (rst_b),
        .i_inc   (w_start),
        .o_count (bus.miss_count)
    );

    sat_counter #(
        .WIDTH    (CNT_W),
        .SATURATE (1'b0)
    ) u_stall_cnt (
        .clk     (clk),
        .rst     (rst_b),
        .i_inc   (bus.freeze),
        .o_count (bus.stall_cycles)
    );

endmodule
